ysyx_220066_ex_muldiv: RTL and testbench
========================================

YSYX_220066_EX_MULDIV -- requirements
Module: ysyx_220066_ex_muldiv

Interface
REQ-001 SHALL provide parameter XLEN, default 64, datapath width (32 or 64).
REQ-002 SHALL provide parameter CNT_W, default $clog2(XLEN)+1, iteration counter width.
REQ-003 SHALL provide the following ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  unit accepts request.
- op  in  3  RV M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- is_w  in  1  32-bit W-variant (ignored when XLEN=32).
- src1, src2  in  XLEN  operands.
- rd_in  in  5  destination tag.
- flush  in  1  kill in-flight op.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  result.
- rd  out  5  tag of result.
- busy  out  1  state != IDLE.

Function
REQ-004 SHALL implement FSM IDLE, MUL, DIV, DONE.
REQ-005 SHALL assert in_ready only in IDLE; handshake completes when in_valid && in_ready.
- Operands, op, is_w and rd_in SHALL be latched on handshake.
- Next state: MUL for op[2]=0, DIV for op[2]=1.
REQ-006 MUL SHALL run radix-2 shift-add, one bit per cycle, on magnitudes with a sign fix-up.
- N iterations, N = 32 if is_w else XLEN.
- Then DONE.
REQ-007 DIV SHALL run restoring division on magnitudes, one quotient bit per cycle, N iterations, then DONE.
- Quotient sign = sign1 XOR sign2.
- Remainder sign = sign1.
REQ-008 Result selection:
- MUL: low N bits of product.
- MULH, MULHSU, MULHU: high N bits, with operand signedness per op.
REQ-009 W variants SHALL operate on src[31:0]:
- Operands sign-extended for signed ops, zero-extended for unsigned ops.
- Final result sign-extended from bit 31 to XLEN.
REQ-010 Divide by zero: quotient all-ones, remainder = dividend (width-adjusted per REQ-009).
REQ-011 Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
REQ-012 DONE SHALL hold out_valid=1 with result and rd stable until out_ready, then return to IDLE.
- out_valid SHALL be 0 in all other states.
REQ-013 Latency from accept to out_valid SHALL be N+1 cycles; no back-to-back overlap.
REQ-014 flush SHALL force IDLE on the next edge from any state and discard the op; no out_valid for it.
- Flush in the same cycle as an in_valid handshake SHALL drop the request.
- Flush takes priority over out_ready.
REQ-015 Counter SHALL count down from N to 0 with no wrap; DONE is entered on the 0 -> terminal transition.

Reset
REQ-016 rst=0 at posedge clk SHALL force IDLE, counter 0, out_valid 0, result 0, rd 0, busy 0, in_ready 1 the following cycle.
- Applies mid-operation; the in-flight op is lost.
REQ-017 rst SHALL have priority over flush and every handshake.

Configuration
REQ-018 Macro YSYX_220066_MDU_FASTPATH_EN:
- Defined: divide by zero, overflow, and any MUL with an operand equal to 0 SHALL go directly to DONE (latency 1).
- Undefined: all ops take N+1 cycles, with results identical to the defined case.

Structure
REQ-019 Package ysyx_220066_mdu_pkg SHALL hold the op encoding localparams, the FSM state typedef, and the W-width constant 32.
REQ-020 Sub-module ysyx_220066_mdu_divstep SHALL implement one restoring subtract/shift step, XLEN-parameterised, purely combinational.

Verification
REQ-021 Bench SHALL cover these scenarios:
- MUL src1=7, src2=-3, XLEN=64 -> result=-21 after 65 cycles; MULHU 2^63 x 4 -> result=2.
- DIV -7 / 2 -> quotient -3; REM -7 % 2 -> -1; DIVU 0xFFFF_FFFF_FFFF_FFFF / 0 -> all-ones; REM x % 0 -> x.
- DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM -> 0; DIVW 0x8000_0000 / -1 -> 0xFFFF_FFFF_8000_0000.
- MULW 0x7FFF_FFFF x 2 -> 0xFFFF_FFFF_FFFF_FFFE after 33 cycles; out_ready held 0 for 5 cycles -> result stable, in_ready 0.
- flush at iteration 10 -> IDLE next cycle with no out_valid; rst=0 mid-DIV -> all outputs 0.
- FASTPATH defined: DIV by 0 -> out_valid 1 cycle after accept; undefined -> 65 cycles, same value.

Source files
------------

// File: rtl/ysyx_220066_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: RV M op encodings,
// FSM state type, W-variant width and operand-signedness helpers.
package ysyx_220066_mdu_pkg;

    localparam int W32 = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    function automatic logic op_src1_signed(input logic [2:0] op);
        logic s;
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
            default:                                    s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic op_src2_signed(input logic [2:0] op);
        logic s;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: s = 1'b1;
            default:                         s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ysyx_220066_mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits. Purely combinational.
module ysyx_220066_mdu_divstep #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_bit,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic            o_qbit
);

    // The extra top bit keeps 2*rem+bit exact when the divisor is near 2^XLEN.
    logic [XLEN:0] w_shift;

    assign w_shift = {i_rem, i_bit};
    assign o_qbit  = (w_shift >= {1'b0, i_divisor});
    assign o_rem   = o_qbit ? (w_shift[XLEN-1:0] - i_divisor) : w_shift[XLEN-1:0];

endmodule

// File: rtl/ysyx_220066_ex_muldiv.sv
// Iterative RV M-extension unit: shift-add multiply and restoring divide, one bit
// per cycle. Define YSYX_220066_MDU_FASTPATH_EN to finish trivial ops in one cycle.
module ysyx_220066_ex_muldiv
    import ysyx_220066_mdu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            is_w,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd,
    output logic            busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  X_ZERO   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  X_ONES   = {XLEN{1'b1}};

    function automatic logic [XLEN-1:0] ext32(input logic [W32-1:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        r          = {XLEN{sgn & v[W32-1]}};
        r[W32-1:0] = v;
        return r;
    endfunction

    mdu_state_e r_state;
    mdu_state_e w_state_nxt;

    logic              r_in_ready, r_out_valid, r_busy;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd;
    logic [1:0]        r_op;
    logic              r_w, r_neg1, r_neg2, r_div0, r_ovf;
    logic [XLEN-1:0]   r_a;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_mcand, r_prod;
    logic [XLEN-1:0]   r_mplier, r_dvd, r_rem, r_dvsr;

    logic              w_hs, w_w_in, w_s1, w_s2, w_neg1, w_neg2;
    logic              w_div0, w_ovf, w_fast, w_last, w_qbit, w_sign;
    logic [XLEN-1:0]   w_a, w_b, w_mag1, w_mag2, w_min_in, w_min_r, w_dvd_init;
    logic [XLEN-1:0]   w_fast_res, w_rem_nxt, w_dvd_step, w_q_fix, w_r_fix;
    logic [XLEN-1:0]   w_mul_res, w_div_res;
    logic [2*XLEN-1:0] w_prod_step, w_prod_fix;
    logic [CNT_W-1:0]  w_n, w_cnt_dec;

    assign w_hs   = in_valid && r_in_ready;
    assign w_w_in = (XLEN > W32) ? is_w : 1'b0;
    assign w_s1   = op_src1_signed(op);
    assign w_s2   = op_src2_signed(op);
    assign w_a    = w_w_in ? ext32(src1[W32-1:0], w_s1) : src1;
    assign w_b    = w_w_in ? ext32(src2[W32-1:0], w_s2) : src2;
    assign w_neg1 = w_s1 & w_a[XLEN-1];
    assign w_neg2 = w_s2 & w_b[XLEN-1];
    assign w_mag1 = w_neg1 ? (X_ZERO - w_a) : w_a;
    assign w_mag2 = w_neg2 ? (X_ZERO - w_b) : w_b;
    assign w_n    = w_w_in ? CNT_W'(W32) : CNT_W'(XLEN);

    assign w_min_in = w_w_in ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
    assign w_min_r  = r_w    ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div0   = op[2] && (w_b == X_ZERO);
    assign w_ovf    = op[2] && !op[0] && (w_a == w_min_in) && (w_b == X_ONES);

    // W dividends start at bit XLEN-1 so the quotient lands in the low 32 bits.
    assign w_dvd_init = w_w_in ? (w_mag1 << W32) : w_mag1;

`ifdef YSYX_220066_MDU_FASTPATH_EN
    logic w_mulz;
    assign w_mulz     = !op[2] && ((w_a == X_ZERO) || (w_b == X_ZERO));
    assign w_fast     = w_div0 || w_ovf || w_mulz;
    assign w_fast_res = w_mulz ? X_ZERO :
                        w_div0 ? (op[1] ? (w_w_in ? ext32(w_a[W32-1:0], 1'b1) : w_a) : X_ONES) :
                                 (op[1] ? X_ZERO : w_min_in);
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = X_ZERO;
`endif

    assign w_last    = (r_cnt <= CNT_ONE);
    assign w_cnt_dec = (r_cnt == CNT_ZERO) ? CNT_ZERO : (r_cnt - CNT_ONE);
    assign w_sign    = r_neg1 ^ r_neg2;

    ysyx_220066_mdu_divstep #(
        .XLEN(XLEN)
    ) u_divstep (
        .i_rem    (r_rem),
        .i_bit    (r_dvd[XLEN-1]),
        .i_divisor(r_dvsr),
        .o_rem    (w_rem_nxt),
        .o_qbit   (w_qbit)
    );

    // Result of the final iteration is formed from the post-step values.
    always_comb begin
        w_prod_step = r_prod + (r_mplier[0] ? r_mcand : {(2*XLEN){1'b0}});
        w_prod_fix  = w_sign ? ({(2*XLEN){1'b0}} - w_prod_step) : w_prod_step;
        if (r_op == 2'b00) begin
            w_mul_res = r_w ? ext32(w_prod_fix[W32-1:0], 1'b1) : w_prod_fix[XLEN-1:0];
        end else begin
            w_mul_res = r_w ? ext32(w_prod_fix[2*W32-1:W32], 1'b1) : w_prod_fix[2*XLEN-1:XLEN];
        end
        w_dvd_step = {r_dvd[XLEN-2:0], w_qbit};
        w_q_fix    = w_sign ? (X_ZERO - w_dvd_step) : w_dvd_step;
        w_r_fix    = r_neg1 ? (X_ZERO - w_rem_nxt) : w_rem_nxt;
        if (r_div0) begin
            w_div_res = r_op[1] ? (r_w ? ext32(r_a[W32-1:0], 1'b1) : r_a) : X_ONES;
        end else if (r_ovf) begin
            w_div_res = r_op[1] ? X_ZERO : w_min_r;
        end else if (r_op[1]) begin
            w_div_res = r_w ? ext32(w_r_fix[W32-1:0], 1'b1) : w_r_fix;
        end else begin
            w_div_res = r_w ? ext32(w_q_fix[W32-1:0], 1'b1) : w_q_fix;
        end
    end

    // Next-state logic; flush wins over every handshake.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_hs) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_fast) begin
                        w_state_nxt = ST_DONE;
                    end else if (op[2]) begin
                        w_state_nxt = ST_DIV;
                    end else begin
                        w_state_nxt = ST_MUL;
                    end
                end
                ST_MUL, ST_DIV: w_state_nxt = w_last ? ST_DONE : r_state;
                ST_DONE:        w_state_nxt = out_ready ? ST_IDLE : ST_DONE;
                default:        w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_result <= X_ZERO;
            r_rd     <= 5'd0;
            r_op     <= 2'd0;
            r_w      <= 1'b0;
            r_neg1   <= 1'b0;
            r_neg2   <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
            r_a      <= X_ZERO;
            r_cnt    <= CNT_ZERO;
            r_mcand  <= {(2*XLEN){1'b0}};
            r_prod   <= {(2*XLEN){1'b0}};
            r_mplier <= X_ZERO;
            r_dvd    <= X_ZERO;
            r_rem    <= X_ZERO;
            r_dvsr   <= X_ZERO;
        end else if (flush) begin
            r_cnt <= CNT_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_rd     <= rd_in;
                        r_op     <= op[1:0];
                        r_w      <= w_w_in;
                        r_neg1   <= w_neg1;
                        r_neg2   <= w_neg2;
                        r_div0   <= w_div0;
                        r_ovf    <= w_ovf;
                        r_a      <= w_a;
                        r_cnt    <= w_fast ? CNT_ZERO : w_n;
                        r_mcand  <= {X_ZERO, w_mag1};
                        r_prod   <= {(2*XLEN){1'b0}};
                        r_mplier <= w_mag2;
                        r_dvd    <= w_dvd_init;
                        r_rem    <= X_ZERO;
                        r_dvsr   <= w_mag2;
                        if (w_fast) begin
                            r_result <= w_fast_res;
                        end
                    end
                end
                ST_MUL: begin
                    r_prod   <= w_prod_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= w_cnt_dec;
                    if (w_last) begin
                        r_result <= w_mul_res;
                    end
                end
                ST_DIV: begin
                    r_dvd <= w_dvd_step;
                    r_rem <= w_rem_nxt;
                    r_cnt <= w_cnt_dec;
                    if (w_last) begin
                        r_result <= w_div_res;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;
    assign rd        = r_rd;

endmodule

// File: tb/tb_ysyx_220066_ex_muldiv.sv
// Directed self-checking bench for ysyx_220066_ex_muldiv (XLEN=64), covering
// results, latency, output hold, flush and mid-operation reset.
module tb_ysyx_220066_ex_muldiv;

`ifdef YSYX_220066_MDU_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk, rst, in_valid, in_ready, is_w, flush, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [63:0] src1, src2, result;
    logic [4:0]  rd_in, rd;
    int          n_checks = 0;
    int          n_errors = 0;

    ysyx_220066_ex_muldiv dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .is_w(is_w), .src1(src1), .src2(src2), .rd_in(rd_in),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .rd(rd), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure cycles from the accept edge (counted as 1) to out_valid.
    task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] t,
                          input logic [63:0] exp, input bit special, input int hold);
        int lat;
        int n;
        lat = (special && FAST) ? 1 : (w ? 33 : 65);
        @(negedge clk);
        check_eq({tag, "_inrdy"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; op = o; is_w = w; src1 = a; src2 = b; rd_in = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_lat"}, 64'(n), 64'(lat));
        check_eq({tag, "_res"}, result, exp);
        check_eq({tag, "_rd"}, {59'd0, rd}, {59'd0, t});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq({tag, "_hold_vld"}, {63'd0, out_valid}, 64'd1);
            check_eq({tag, "_hold_res"}, result, exp);
            check_eq({tag, "_hold_inrdy"}, {63'd0, in_ready}, 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_drop"}, {63'd0, out_valid}, 64'd0);
    endtask

    int n_ov;

    initial begin
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = 3'd0; is_w = 1'b0; src1 = 64'd0; src2 = 64'd0; rd_in = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_inrdy", {63'd0, in_ready}, 64'd1);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_vld", {63'd0, out_valid}, 64'd0);
        check_eq("rst_res", result, 64'd0);
        check_eq("rst_rd", {59'd0, rd}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("mul",     3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 0);
        run_op("mulhu",   3'b011, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'd2, 64'd2, 1'b0, 0);
        run_op("mulh",    3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'd0, 1'b0, 0);
        run_op("mulhsu",  3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        run_op("mulzero", 3'b000, 1'b0, 64'd0, 64'd5, 5'd5, 64'd0, 1'b1, 0);
        run_op("div",     3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0);
        run_op("rem",     3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        run_op("divu",    3'b101, 1'b0, 64'd100, 64'd7, 5'd8, 64'd14, 1'b0, 0);
        run_op("remu",    3'b111, 1'b0, 64'd100, 64'd7, 5'd9, 64'd2, 1'b0, 0);
        run_op("divu0",   3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
        run_op("rem0",    3'b110, 1'b0, 64'd12345, 64'd0, 5'd11, 64'd12345, 1'b1, 0);
        run_op("divovf",  3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 64'h8000_0000_0000_0000, 1'b1, 0);
        run_op("removf",  3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 64'd0, 1'b1, 0);
        run_op("divwovf", 3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 64'hFFFF_FFFF_8000_0000, 1'b1, 0);
        run_op("divuw",   3'b101, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd2, 5'd15, 64'h0000_0000_7FFF_FFFF, 1'b0, 0);
        run_op("mulw",    3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd16, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 5);

        // Flush at the tenth iteration of a multiply.
        @(negedge clk);
        in_valid = 1'b1; op = 3'b000; is_w = 1'b0; src1 = 64'd7; src2 = 64'd3; rd_in = 5'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_busy", {63'd0, busy}, 64'd0);
        check_eq("flush_inrdy", {63'd0, in_ready}, 64'd1);
        check_eq("flush_vld", {63'd0, out_valid}, 64'd0);

        // Flush together with a handshake drops the request.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; op = 3'b101; src1 = 64'd100; src2 = 64'd7; rd_in = 5'd20;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check_eq("flushhs_busy", {63'd0, busy}, 64'd0);
        n_ov = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) n_ov++;
        end
        check_eq("flush_no_out", 64'(n_ov), 64'd0);

        // Reset in the middle of a divide.
        @(negedge clk);
        in_valid = 1'b1; op = 3'b100; is_w = 1'b0; src1 = 64'd100; src2 = 64'd7; rd_in = 5'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("middiv_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("mrst_vld", {63'd0, out_valid}, 64'd0);
        check_eq("mrst_res", result, 64'd0);
        check_eq("mrst_rd", {59'd0, rd}, 64'd0);
        check_eq("mrst_busy", {63'd0, busy}, 64'd0);
        check_eq("mrst_inrdy", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b1;

        run_op("div_after_rst", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd21, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
